uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 154 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding an 8N1 UART transmitter; UART_TX_SCHED_PARITY_EN adds an even-parity bit.
// Grant is registered: gnt/busy/start bit appear on the clk after req is seen in IDLE; req is ignored while busy.
module uart_tx_sched #(
  parameter int N_REQ      = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_en,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_SCHED_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     bit_idx, bit_nxt;
  logic [7:0]     tx_byte, byte_nxt;
  logic [PW-1:0]  ptr, ptr_nxt;
  logic [PW-1:0]  pick;
  logic           found;
  logic [N_REQ-1:0] gnt_nxt;
  logic           tx_nxt, busy_nxt, done_nxt, period_end;
  int             idx;

  // ptr is the index just after the last winner, so the search starts there.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_idx;
    byte_nxt   = tx_byte;
    ptr_nxt    = ptr;
    gnt_nxt    = '0;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    tx_nxt     = 1'b1;
    period_end = baud_en && (cnt == CW'(OVERSAMPLE - 1));

    if (state != IDLE && baud_en) begin
      cnt_nxt = period_end ? '0 : cnt + CW'(1);
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (found) begin
          gnt_nxt   = ONE << pick;
          byte_nxt  = data[{pick, 3'b000} +: 8];
          ptr_nxt   = (pick == PW'(N_REQ - 1)) ? '0 : pick + PW'(1);
          bit_nxt   = 3'd0;
          busy_nxt  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (period_end) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
        end
      end
      DATA: begin
        if (period_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_SCHED_PARITY_EN
      PARITY: begin
        if (period_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (period_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = byte_nxt[bit_nxt];
`ifdef UART_TX_SCHED_PARITY_EN
      PARITY:  tx_nxt = ^byte_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_byte <= '0;
      ptr     <= '0;
      gnt     <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      tx_byte <= byte_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: tick-counting frame model with per-cycle compare plus directed literal checks.
module tb_uart_tx_sched;
  localparam int N  = 4;
  localparam int OS = 16;
`ifdef UART_TX_SCHED_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           baud_en = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   gnt;
  logic           tx, busy, done;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(N), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .req(req), .data(data),
    .gnt(gnt), .tx(tx), .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bmode = 3;
  bit auto_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Frame model: a frame is FB*OS baud ticks after the grant; bit slot = ticks/OS.
  logic         m_active;
  int           m_ticks;
  logic [7:0]   m_byte;
  int           m_last;
  logic [N-1:0] m_gnt;
  logic         m_done;
  int           m_i;
  bit           m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_ticks = 0; m_byte = '0; m_last = N - 1;
      m_gnt = '0; m_done = 1'b0;
    end else begin
      m_gnt  = '0;
      m_done = 1'b0;
      if (!m_active) begin
        m_hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
          m_i = (m_last + k) % N;
          if (!m_hit && req[m_i]) begin
            m_hit    = 1'b1;
            m_last   = m_i;
            m_active = 1'b1;
            m_ticks  = 0;
            m_byte   = data[8*m_i +: 8];
            m_gnt    = '0;
            m_gnt[m_i] = 1'b1;
          end
        end
      end else begin
        if (baud_en) m_ticks++;
        if (m_ticks == FB * OS) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
  end

  function automatic logic exp_tx();
    int pos;
    if (!m_active) return 1'b1;
    pos = m_ticks / OS;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_byte[pos-1];
`ifdef UART_TX_SCHED_PARITY_EN
    if (pos == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_gnt", gnt, 0);
    end else begin
      check("gnt", gnt, m_gnt);
      check("tx", tx, exp_tx());
      check("busy", busy, m_active);
      check("done", done, m_done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (bmode)
      0:       baud_en = ($urandom_range(0, 1) == 0);
      1:       baud_en = (cyc % 55 == 0);
      2:       baud_en = 1'b0;
      default: baud_en = 1'b1;
    endcase
    if (auto_req) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
      end
      data = $urandom;
    end
  endtask

  task automatic wait_gnt(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (gnt != 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("gnt_wait");
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("done_wait");
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int   exp_order [5] = '{0, 1, 2, 3, 0};
`ifdef UART_TX_SCHED_PARITY_EN
  logic bits_a5 [FB] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
  logic bits_a5 [FB] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

  initial begin
    bit ok;
    int rel, done_cyc, g, t0, target;

    // Reset with all requests pending: outputs must stay idle.
    req = 4'b1111;
    bmode = 3;
    repeat (3) step();
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_gnt", gnt, 4'b0000);
    check("reset_done", done, 1'b0);
    rst_n = 1'b1;
    rel = cyc;

    // All four held: round robin 0,1,2,3,0 with 1-clk turnaround.
    done_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(400, ok);
      if (k == 0) check("first_gnt_latency", cyc - rel, 1);
      else        check("done_to_gnt_gap", cyc - done_cyc, 1);
      check("rr_order", oh2idx(gnt), exp_order[k]);
      wait_done(400, ok);
      done_cyc = cyc;
    end
    req = '0;

    // 0xA5 from requester 0, baud tick every 55 clks.
    data = $urandom;
    data[7:0] = 8'hA5;
    req = 4'b0001;
    bmode = 1;
    wait_gnt(10, ok);
    check("a5_gnt", gnt, 4'b0001);
    g = cyc;
    req = '0;
    data = $urandom;
    t0 = g + (55 - g % 55) % 55;
    for (int k = 0; k < FB; k++) begin
      target = t0 + (16 * k + 8) * 55;
      while (cyc < target) step();
      check("a5_bit", tx, bits_a5[k]);
    end
    target = t0 + (16 * FB - 1) * 55 + 1;
    while (cyc < target - 1) step();
    check("a5_busy_before_end", busy, 1'b1);
    step();
    check("a5_done", done, 1'b1);
    check("a5_busy_after_end", busy, 1'b0);
    step();
    check("a5_done_pulse", done, 1'b0);

    // Reset in the middle of data bit 3, then a fresh frame from requester 2.
    bmode = 3;
    data = $urandom;
    req = 4'b0001;
    wait_gnt(5, ok);
    req = '0;
    repeat (70) step();
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    rel = cyc;
    req = 4'b0100;
    wait_gnt(5, ok);
    check("post_rst_gnt", gnt, 4'b0100);
    check("post_rst_latency", cyc - rel, 1);
    req = '0;
    wait_done(300, ok);

    // baud_en stalled for 1000 clks during the start bit.
    req = 4'b0001;
    wait_gnt(5, ok);
    g = cyc;
    req = '0;
    repeat (5) step();
    bmode = 2;
    repeat (500) step();
    check("stall_tx", tx, 1'b0);
    check("stall_busy", busy, 1'b1);
    repeat (500) step();
    check("stall_tx_end", tx, 1'b0);
    bmode = 3;
    wait_done(400, ok);
    check("stall_frame_len", cyc - g, FB * OS + 1000);

    // Request raised mid-frame is only granted the clk after done.
    req = 4'b0001;
    wait_gnt(5, ok);
    req = '0;
    repeat (20) step();
    req = 4'b0010;
    wait_done(300, ok);
    check("late_req_no_gnt", gnt, 4'b0000);
    step();
    check("late_req_gnt", gnt, 4'b0010);
    req = '0;
    wait_done(300, ok);

    // Random traffic against the model.
    bmode = 0;
    auto_req = 1'b1;
    repeat (6000) step();
    auto_req = 1'b0;
    req = '0;
    for (int i = 0; i < 2000 && busy; i++) step();
    if (busy) fail_now("drain");
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
